// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: operating modes, FSM
// states, the key-code table and small row-decoding helpers.
package keypad_scan_pkg;

    // Machine operating modes carried on the state input (2'b11 is unused).
    typedef enum logic [1:0] {
        MODE_ORDER  = 2'b00,
        MODE_CUSTOM = 2'b01,
        MODE_START  = 2'b10
    } mode_e;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        ST_SCAN     = 2'b00,
        ST_DEBOUNCE = 2'b01,
        ST_RELEASE  = 2'b10
    } fsm_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Key codes indexed by {row, col}; element 0 is row 0 / column 0.
    // Row 0: 1 2 3 A, row 1: 4 5 6 B, row 2: 7 8 9 C, row 3: * 0 # D.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, KEY_HASH, 4'h0, KEY_STAR,
        4'hC, 4'h9,     4'h8, 4'h7,
        4'hB, 4'h6,     4'h5, 4'h4,
        4'hA, 4'h3,     4'h2, 4'h1
    };

    // True when exactly one active-low row line is pulled down.
    function automatic logic one_low(input logic [3:0] row_n);
        return ($countones(~row_n) == 1);
    endfunction

    // Index of the low row line; only meaningful when one_low() holds.
    function automatic logic [1:0] row_index(input logic [3:0] row_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!row_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and machine-side signals of the scanner grouped in one bundle.
// The scanner is the slave; whoever drives ROW and state is the master.
interface keypad_scan_if;
    logic [3:0] ROW;
    logic [1:0] state;
    logic [3:0] COL;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] drink;
    logic [3:0] size;
    logic       confirm;

    modport slave (
        input  ROW, state,
        output COL, key_valid, key_code, drink, size, confirm
    );

    modport master (
        output ROW, state,
        input  COL, key_valid, key_code, drink, size, confirm
    );
endinterface

// File: rtl/keypad_scan_tick.sv
// Free-running divider producing a one-cycle scan tick every 2^SCAN_DIV clocks.
module scan_tick #(
    parameter int SCAN_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [SCAN_DIV-1:0] div_reg;

    // Divider counts continuously and wraps; tick marks its last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_reg <= '0;
        else     div_reg <= div_reg + 1'b1;
    end

    assign tick = &div_reg;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates one active-low column, debounces a
// single pressed key, reports it once, then waits for a debounced release.
// Accepted keys update the drink or size selection depending on the mode.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 16,
    parameter int DEB_TICKS = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.slave  kp
);

    localparam int              CW      = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0]   DEB_MAX = CW'(DEB_TICKS);

    logic            tick;
    fsm_e            fsm_reg, fsm_next;
    logic [1:0]      col_idx_reg, col_idx_next;
    logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [3:0]      row_lat_reg, row_lat_next;
    logic            kv_reg, kv_next;
    logic            confirm_reg, confirm_next;
    logic [3:0]      key_code_reg, key_code_next;
    logic [2:0]      drink_reg, drink_next;
    logic [3:0]      size_reg, size_next;
    logic [3:0]      code_sel;

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Saturating increment so the debounce counter never wraps.
    assign cnt_inc  = (cnt_reg == DEB_MAX) ? cnt_reg : cnt_reg + 1'b1;
    assign code_sel = KEY_MAP[{row_index(row_lat_reg), col_idx_reg}];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_reg <= ST_SCAN;
        else     fsm_reg <= fsm_next;
    end

    // Next-state logic: ROW is only looked at on scan ticks.
    always_comb begin
        fsm_next      = fsm_reg;
        col_idx_next  = col_idx_reg;
        cnt_next      = cnt_reg;
        row_lat_next  = row_lat_reg;
        kv_next       = 1'b0;
        confirm_next  = 1'b0;
        key_code_next = key_code_reg;
        if (tick) begin
            case (fsm_reg)
                ST_SCAN: begin
                    if (one_low(kp.ROW)) begin
                        row_lat_next = kp.ROW;
                        cnt_next     = '0;
                        fsm_next     = ST_DEBOUNCE;
                    end else begin
                        col_idx_next = col_idx_reg + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (kp.ROW == row_lat_reg) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DEB_MAX) begin
                            kv_next       = 1'b1;
                            key_code_next = code_sel;
                            confirm_next  = (code_sel == KEY_HASH);
                            cnt_next      = '0;
                            fsm_next      = ST_RELEASE;
                        end
                    end else begin
                        fsm_next     = ST_SCAN;
                        col_idx_next = col_idx_reg + 2'd1;
                    end
                end
                ST_RELEASE: begin
                    if (kp.ROW == 4'hF) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == DEB_MAX) begin
                            cnt_next     = '0;
                            fsm_next     = ST_SCAN;
                            col_idx_next = col_idx_reg + 2'd1;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                default: fsm_next = ST_SCAN;
            endcase
        end
    end

    // Selection update in the key_valid cycle, using the mode seen then.
    always_comb begin
        drink_next = drink_reg;
        size_next  = size_reg;
        if (kv_reg) begin
            if (kp.state == MODE_ORDER && key_code_reg <= 4'd6)
                drink_next = key_code_reg[2:0];
            if (kp.state == MODE_CUSTOM && key_code_reg <= 4'd9)
                size_next = key_code_reg;
        end
    end

    // Datapath registers: column, counter, latched row, outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_idx_reg  <= 2'd0;
            cnt_reg      <= '0;
            row_lat_reg  <= 4'hF;
            kv_reg       <= 1'b0;
            confirm_reg  <= 1'b0;
            key_code_reg <= 4'h0;
            drink_reg    <= 3'd0;
            size_reg     <= 4'd0;
        end else begin
            col_idx_reg  <= col_idx_next;
            cnt_reg      <= cnt_next;
            row_lat_reg  <= row_lat_next;
            kv_reg       <= kv_next;
            confirm_reg  <= confirm_next;
            key_code_reg <= key_code_next;
            drink_reg    <= drink_next;
            size_reg     <= size_next;
        end
    end

    assign kp.COL       = ~(4'b0001 << col_idx_reg);
    assign kp.key_valid = kv_reg;
    assign kp.confirm   = confirm_reg;
    assign kp.key_code  = key_code_reg;
    assign kp.drink     = drink_reg;
    assign kp.size      = size_reg;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad contact model drives ROW from COL, and a
// tick-level reference model predicts every output on every clock.
module tb_keypad_scan;

    localparam int SD = 2;
    localparam int DT = 4;
    localparam int TICK_PERIOD = 1 << SD;

    logic clk;
    logic rst;
    keypad_scan_if kp();

    keypad_scan #(.SCAN_DIV(SD), .DEB_TICKS(DT)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad contacts
    bit k_press, k_ghost;
    int k_row, k_col;

    function automatic logic [3:0] keypad(input logic [3:0] col_n, input bit press,
                                          input bit ghost, input int r, input int c);
        logic [3:0] rn;
        rn = 4'hF;
        if (ghost) rn = 4'b1100;
        else if (press && col_n[c] == 1'b0) rn[r] = 1'b0;
        return rn;
    endfunction

    assign kp.ROW = keypad(kp.COL, k_press, k_ghost, k_row, k_col);

    // Reference model state (tick level)
    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    int m_phase, m_col, m_cnt, m_div, m_lrow, m_code, m_drink, m_size;
    logic [3:0] m_lat;
    bit m_kv, m_conf, m_last_tick, rnd_state;

    int checks, errors, n_kv, n_conf, t;
    logic [3:0] c0, c_exp;

    function automatic logic [3:0] col_mask(input int idx);
        logic [3:0] m;
        m = 4'hF;
        m[idx] = 1'b0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_col = 0; m_cnt = 0; m_div = 0; m_lrow = 0; m_lat = 4'hF;
        m_code = 0; m_drink = 0; m_size = 0; m_kv = 0; m_conf = 0; m_last_tick = 0;
    endtask

    // One clock: predict, clock, compare every output.
    task automatic step();
        bit tk, nkv, nconf;
        logic [3:0] s;
        if (rnd_state && $urandom_range(7) == 0) kp.state = 2'($urandom_range(3));
        tk = (m_div == TICK_PERIOD - 1);
        nkv = 0; nconf = 0;
        if (m_kv) begin
            if (kp.state == 2'b00 && m_code <= 6) m_drink = m_code;
            if (kp.state == 2'b01 && m_code <= 9) m_size = m_code;
        end
        if (tk) begin
            s = keypad(col_mask(m_col), k_press, k_ghost, k_row, k_col);
            if (m_phase == 0) begin
                if ($countones(~s) == 1) begin
                    m_lat = s; m_cnt = 0; m_phase = 1;
                    for (int i = 0; i < 4; i++) if (!s[i]) m_lrow = i;
                end else m_col = (m_col + 1) % 4;
            end else if (m_phase == 1) begin
                if (s == m_lat) begin
                    m_cnt = (m_cnt < DT) ? m_cnt + 1 : DT;
                    if (m_cnt == DT) begin
                        nkv = 1; m_code = keymap[m_lrow * 4 + m_col];
                        nconf = (m_code == 15); m_phase = 2; m_cnt = 0;
                    end
                end else begin
                    m_phase = 0; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (s == 4'hF) m_cnt = (m_cnt < DT) ? m_cnt + 1 : DT;
                else m_cnt = 0;
                if (m_cnt == DT) begin
                    m_phase = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
                end
            end
        end
        m_kv = nkv; m_conf = nconf; m_last_tick = tk;
        m_div = (m_div + 1) % TICK_PERIOD;
        @(posedge clk);
        #1;
        chk("col", 8'(kp.COL), 8'(col_mask(m_col)));
        chk("key_valid", 8'(kp.key_valid), 8'(m_kv));
        chk("confirm", 8'(kp.confirm), 8'(m_conf));
        chk("key_code", 8'(kp.key_code), 8'(m_code));
        chk("drink", 8'(kp.drink), 8'(m_drink));
        chk("size", 8'(kp.size), 8'(m_size));
        if (kp.key_valid === 1'b1) n_kv++;
        if (kp.confirm === 1'b1) n_conf++;
    endtask

    task automatic run_ticks(input int n);
        int cnt;
        cnt = 0;
        while (cnt < n) begin
            step();
            if (m_last_tick) cnt++;
        end
    endtask

    task automatic settle();
        k_press = 0; k_ghost = 0;
        run_ticks(2 * DT + 6);
    endtask

    initial begin
        checks = 0; errors = 0; rnd_state = 0;
        k_press = 0; k_ghost = 0; k_row = 0; k_col = 0;
        kp.state = 2'b00;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col", 8'(kp.COL), 8'h0E);
        chk("rst_kv", 8'(kp.key_valid), 8'h00);
        chk("rst_code", 8'(kp.key_code), 8'h00);
        chk("rst_drink", 8'(kp.drink), 8'h00);
        chk("rst_size", 8'(kp.size), 8'h00);
        rst = 1'b0;

        // Press '5' in order mode
        kp.state = 2'b00; k_row = 1; k_col = 1; k_press = 1; n_kv = 0;
        run_ticks(20);
        settle();
        chk("press_pulses", 8'(n_kv), 8'd1);
        chk("press_code", 8'(kp.key_code), 8'h5);
        chk("press_drink", 8'(kp.drink), 8'd5);
        chk("press_size", 8'(kp.size), 8'd0);
        $display("txn press key=5 state=00 pulses=%0d drink=%0d", n_kv, kp.drink);

        // Customize: '9' then 'A'
        kp.state = 2'b01; k_row = 2; k_col = 2; k_press = 1; n_kv = 0;
        run_ticks(20);
        settle();
        chk("cust_size9", 8'(kp.size), 8'd9);
        k_row = 0; k_col = 3; k_press = 1; n_kv = 0;
        run_ticks(20);
        settle();
        chk("cust_a_pulses", 8'(n_kv), 8'd1);
        chk("cust_a_code", 8'(kp.key_code), 8'hA);
        chk("cust_a_size", 8'(kp.size), 8'd9);
        $display("txn customize keys=9,A size=%0d", kp.size);

        // Bounce on '2', then hold
        kp.state = 2'b00; k_row = 0; k_col = 1; k_press = 0; n_kv = 0;
        for (int i = 0; i < 10; i++) begin
            k_press = ~k_press;
            run_ticks(1);
        end
        k_press = 1;
        run_ticks(20);
        settle();
        chk("bounce_pulses", 8'(n_kv), 8'd1);
        chk("bounce_drink", 8'(kp.drink), 8'd2);
        $display("txn bounce key=2 pulses=%0d", n_kv);

        // Ghost pattern
        k_ghost = 1; n_kv = 0; c0 = kp.COL;
        run_ticks(1);
        c_exp = {c0[2:0], c0[3]};
        chk("ghost_rotate", 8'(kp.COL), 8'(c_exp));
        run_ticks(12);
        settle();
        chk("ghost_pulses", 8'(n_kv), 8'd0);
        $display("txn ghost ROW=1100 pulses=%0d", n_kv);

        // Hold '#' under start mode
        kp.state = 2'b10; k_row = 3; k_col = 2; k_press = 1; n_kv = 0; n_conf = 0;
        run_ticks(50);
        k_press = 0; c0 = kp.COL; t = 0;
        while (kp.COL === c0 && t < 20) begin
            run_ticks(1);
            t++;
        end
        chk("resume_ticks", 8'(t), 8'(DT));
        settle();
        chk("hold_pulses", 8'(n_kv), 8'd1);
        chk("hold_confirm", 8'(n_conf), 8'd1);
        chk("hold_code", 8'(kp.key_code), 8'hF);
        chk("hold_drink", 8'(kp.drink), 8'd2);
        chk("hold_size", 8'(kp.size), 8'd9);
        $display("txn hold key=# pulses=%0d confirms=%0d resume=%0d", n_kv, n_conf, t);

        // Randomized presses with mode changes
        rnd_state = 1;
        for (int i = 0; i < 30; i++) begin
            k_row = $urandom_range(3); k_col = $urandom_range(3);
            k_ghost = ($urandom_range(7) == 0);
            k_press = 1; n_kv = 0;
            run_ticks($urandom_range(12));
            k_press = 0; k_ghost = 0;
            run_ticks($urandom_range(12));
            $display("txn random %0d key=r%0dc%0d pulses=%0d drink=%0d size=%0d",
                     i, k_row, k_col, n_kv, kp.drink, kp.size);
        end
        rnd_state = 0;
        settle();

        // Reset in the middle of debounce
        kp.state = 2'b00; k_row = 2; k_col = 0; k_press = 1; t = 0;
        while (m_phase != 1 && t < 12) begin
            run_ticks(1);
            t++;
        end
        chk("reached_debounce", 8'(m_phase), 8'd1);
        run_ticks(1);
        rst = 1'b1; k_press = 0;
        #1;
        chk("mid_rst_col", 8'(kp.COL), 8'h0E);
        chk("mid_rst_kv", 8'(kp.key_valid), 8'h00);
        chk("mid_rst_confirm", 8'(kp.confirm), 8'h00);
        chk("mid_rst_code", 8'(kp.key_code), 8'h00);
        chk("mid_rst_drink", 8'(kp.drink), 8'h00);
        chk("mid_rst_size", 8'(kp.size), 8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_kv = 0;
        run_ticks(20);
        chk("post_rst_pulses", 8'(n_kv), 8'd0);
        $display("txn reset mid-debounce pulses_after=%0d", n_kv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
